// File: rtl/rv32_pkg.sv
// Shared RV32 encodings: XLEN and the load funct3 (dm_select) values.
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

endpackage

// File: rtl/load_extract.sv
// MEM/WB load formatter: byte/half/word extraction with sign/zero extension.
// Misalignment detection and sticky status flag exist only with LOADBLOCK_MISALIGN_CHECK_EN.
module load_extract
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            nrst,
   input  logic [XLEN-1:0] data,
   input  logic [1:0]      byte_offset,
   input  logic [2:0]      dm_select,
   input  logic            load_valid,
   input  logic            misaligned_clr,
   output logic [XLEN-1:0] loaddata,
   output logic            misaligned,
   output logic            misaligned_q
);

   logic [XLEN-1:0] byte_shift;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;

   assign byte_shift = data >> {byte_offset, 3'b000};
   assign byte_sel   = byte_shift[7:0];
   // Halfword select deliberately ignores offset bit 0.
   assign half_sel   = byte_offset[1] ? data[31:16] : data[15:0];

   always_comb begin
      loaddata = '0;
      case (dm_select)
         LB:      loaddata = {{24{byte_sel[7]}}, byte_sel};
         LBU:     loaddata = {24'h0, byte_sel};
         LH:      loaddata = {{16{half_sel[15]}}, half_sel};
         LHU:     loaddata = {16'h0, half_sel};
         LW:      loaddata = data;
         default: loaddata = '0;
      endcase
   end

`ifdef LOADBLOCK_MISALIGN_CHECK_EN
   logic flag_q;
   logic flag_d;

   always_comb begin
      misaligned = 1'b0;
      case (dm_select)
         LH, LHU: misaligned = byte_offset[0];
         LW:      misaligned = (byte_offset != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   // Acknowledge from the trap handler takes priority over a new event.
   always_comb begin
      flag_d = flag_q;
      if (misaligned_clr)
         flag_d = 1'b0;
      else if (load_valid && misaligned)
         flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         flag_q <= 1'b0;
      else
         flag_q <= flag_d;
   end

   assign misaligned_q = flag_q;
`else
   logic unused_status_inputs;
   assign unused_status_inputs = &{1'b0, clk, nrst, load_valid, misaligned_clr};
   assign misaligned   = 1'b0;
   assign misaligned_q = 1'b0;
`endif

endmodule

// File: tb/tb_load_extract.sv
// Scoreboard bench for load_extract; expectations follow LOADBLOCK_MISALIGN_CHECK_EN.
module tb_load_extract;

   localparam logic [2:0] S_LB  = 3'd0;
   localparam logic [2:0] S_LH  = 3'd1;
   localparam logic [2:0] S_LW  = 3'd2;
   localparam logic [2:0] S_UD  = 3'd3;
   localparam logic [2:0] S_LBU = 3'd4;
   localparam logic [2:0] S_LHU = 3'd5;
   localparam logic [31:0] WORD = 32'hADE1B055;

`ifdef LOADBLOCK_MISALIGN_CHECK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] data = WORD;
   logic [1:0]  byte_offset = 2'd0;
   logic [2:0]  dm_select = S_LB;
   logic        load_valid = 1'b0;
   logic        misaligned_clr = 1'b0;
   logic [31:0] loaddata;
   logic        misaligned;
   logic        misaligned_q;

   typedef struct {
      string       name;
      logic [31:0] ld;
      logic        mis;
      logic        misq;
   } exp_t;

   exp_t exp_q[$];
   logic chk_req = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference state of the sticky flag, advanced once per clock edge.
   logic model_q = 1'b0;
   logic cur_lv = 1'b0, cur_clr = 1'b0, cur_mis = 1'b0, cur_rstn = 1'b0;

   always #5 clk = ~clk;

   load_extract dut (
      .clk(clk),
      .nrst(nrst),
      .data(data),
      .byte_offset(byte_offset),
      .dm_select(dm_select),
      .load_valid(load_valid),
      .misaligned_clr(misaligned_clr),
      .loaddata(loaddata),
      .misaligned(misaligned),
      .misaligned_q(misaligned_q)
   );

   // Monitor: compares whenever the stimulus side presents a transaction.
   always @(negedge clk) begin
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: output presented with no expectation queued");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (loaddata !== e.ld || misaligned !== e.mis || misaligned_q !== e.misq) begin
               errors++;
               $display("FAIL %s: got ld=%08h mis=%0b misq=%0b, expected ld=%08h mis=%0b misq=%0b",
                        e.name, loaddata, misaligned, misaligned_q, e.ld, e.mis, e.misq);
            end else begin
               $display("ok   %s: ld=%08h mis=%0b misq=%0b", e.name, loaddata, misaligned, misaligned_q);
            end
         end
      end
   end

   task automatic drive(input string name, input logic [2:0] sel, input logic [1:0] off,
                        input logic lv, input logic clr, input logic rstn,
                        input logic [31:0] exp_ld, input logic exp_mis_raw);
      exp_t e;
      @(posedge clk);
      if (!cur_rstn)                model_q = 1'b0;
      else if (cur_clr)             model_q = 1'b0;
      else if (cur_lv && cur_mis)   model_q = 1'b1;
      #1;
      dm_select      = sel;
      byte_offset    = off;
      load_valid     = lv;
      misaligned_clr = clr;
      nrst           = rstn;
      cur_lv   = lv;
      cur_clr  = clr;
      cur_rstn = rstn;
      cur_mis  = EN & exp_mis_raw;
      if (!rstn) model_q = 1'b0;
      e.name = name;
      e.ld   = exp_ld;
      e.mis  = cur_mis;
      e.misq = model_q;
      exp_q.push_back(e);
      chk_req = 1'b1;
      @(negedge clk);
      #1 chk_req = 1'b0;
   endtask

   logic [31:0] lb_exp  [4] = '{32'h00000055, 32'hFFFFFFB0, 32'hFFFFFFE1, 32'hFFFFFFAD};
   logic [31:0] lbu_exp [4] = '{32'h00000055, 32'h000000B0, 32'h000000E1, 32'h000000AD};
   logic [31:0] lh_exp  [4] = '{32'hFFFFB055, 32'hFFFFB055, 32'hFFFFADE1, 32'hFFFFADE1};
   logic [31:0] lhu_exp [4] = '{32'h0000B055, 32'h0000B055, 32'h0000ADE1, 32'h0000ADE1};
   logic        lh_mis  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic        lw_mis  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      // Reset held: even a valid misaligned load must not set the flag.
      drive("reset_hold", S_LW, 2'd1, 1'b1, 1'b0, 1'b0, WORD, 1'b1);
      drive("reset_release", S_LB, 2'd0, 1'b0, 1'b0, 1'b1, 32'h00000055, 1'b0);

      for (int i = 0; i < 4; i++) begin
         drive($sformatf("LB_off%0d", i),  S_LB,  2'(i), 1'b0, 1'b0, 1'b1, lb_exp[i],  1'b0);
         drive($sformatf("LBU_off%0d", i), S_LBU, 2'(i), 1'b0, 1'b0, 1'b1, lbu_exp[i], 1'b0);
         drive($sformatf("LH_off%0d", i),  S_LH,  2'(i), 1'b0, 1'b0, 1'b1, lh_exp[i],  lh_mis[i]);
         drive($sformatf("LHU_off%0d", i), S_LHU, 2'(i), 1'b0, 1'b0, 1'b1, lhu_exp[i], lh_mis[i]);
         drive($sformatf("LW_off%0d", i),  S_LW,  2'(i), 1'b0, 1'b0, 1'b1, WORD,       lw_mis[i]);
      end
      drive("undef3", S_UD, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      drive("undef6", 3'd6, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      drive("undef7", 3'd7, 2'd3, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

      // Sticky flag: set, hold, clear-wins, no set without load_valid.
      drive("st_set_event", S_LW, 2'd1, 1'b1, 1'b0, 1'b1, WORD, 1'b1);
      drive("st_flag_set",  S_LW, 2'd0, 1'b0, 1'b0, 1'b1, WORD, 1'b0);
      drive("st_flag_hold", S_LB, 2'd2, 1'b0, 1'b0, 1'b1, 32'hFFFFFFE1, 1'b0);
      drive("st_clr_and_set", S_LH, 2'd1, 1'b1, 1'b1, 1'b1, 32'hFFFFB055, 1'b1);
      drive("st_clr_won",   S_LHU, 2'd3, 1'b0, 1'b0, 1'b1, 32'h0000ADE1, 1'b1);
      drive("st_no_valid",  S_LW, 2'd0, 1'b0, 1'b0, 1'b1, WORD, 1'b0);
      drive("st_set_again", S_LW, 2'd2, 1'b1, 1'b0, 1'b1, WORD, 1'b1);
      drive("st_flag_again", S_LBU, 2'd1, 1'b0, 1'b0, 1'b1, 32'h000000B0, 1'b0);
      // Asynchronous reset mid-operation: flag drops before the next edge, data path unaffected.
      drive("st_mid_reset", S_LH, 2'd2, 1'b0, 1'b0, 1'b0, 32'hFFFFADE1, 1'b0);
      drive("st_after_reset", S_LW, 2'd0, 1'b0, 1'b0, 1'b1, WORD, 1'b0);

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
